btn_reader: RTL and testbench

Input-side counterpart of the LED output path. It reads NUM_BTN raw push-button pins and synchronises each one to clk. Each button is debounced independently. The block produces a clean level, single-cycle press/release pulses, and hold/auto-repeat pulses, for use by board-level tops (e.g. to step or reset LED counters).

---
 rtl/btn_reader_if.sv | 15 +
 rtl/btn_reader.sv | 145 ++++++++++++++
 tb/tb_btn_reader.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/btn_reader_if.sv
// Button reader bus: raw pins in, debounced level and event pulses out.
interface btn_reader_if #(
  parameter int NUM_BTN = 4
);
  logic [NUM_BTN-1:0] i_btn;
  logic [NUM_BTN-1:0] o_state;
  logic [NUM_BTN-1:0] o_press;
  logic [NUM_BTN-1:0] o_release;
  logic [NUM_BTN-1:0] o_hold;

  // Board/testbench side drives the pins and observes the events.
  modport master (output i_btn, input o_state, o_press, o_release, o_hold);
  // Reader side.
  modport slave  (input i_btn, output o_state, o_press, o_release, o_hold);
endinterface

// File: rtl/btn_reader.sv
// Push-button reader: per-channel 2-flop sync, debounce, press/release
// pulses and hold/auto-repeat pulses. Channels are fully independent.
module btn_reader #(
  parameter int NUM_BTN       = 4,
  parameter int ACTIVE_LOW    = 1,
  parameter int DB_CYCLES     = 500000,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic         clk,
  input  logic         rst_n,
  btn_reader_if.slave  bus
);

  // Idle pin level; also the XOR mask that normalises samples to 1 = pressed.
  localparam logic INACT = (ACTIVE_LOW != 0);

  localparam int DW  = (DB_CYCLES > 1)     ? $clog2(DB_CYCLES)     : 1;
  localparam int HW0 = (HOLD_CYCLES > 1)   ? $clog2(HOLD_CYCLES)   : 1;
  localparam int RW0 = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  // One hold counter serves both the initial hold and the repeat period.
  localparam int HW  = (HW0 > RW0) ? HW0 : RW0;

  localparam logic [DW-1:0] DB_TC   = DW'(DB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_TC = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] REP_TC  = HW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {HS_IDLE, HS_PRESSED, HS_REPEAT} hstate_e;

  logic [NUM_BTN-1:0] state_v, press_v, rel_v, hold_v;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    logic          s1_q, s2_q, p;
    logic          state_q, state_d;
    logic          press_q, press_d, rel_q, rel_d, hold_q, hold_d;
    logic [DW-1:0] dc_q, dc_d;
    logic [HW-1:0] hc_q, hc_d;
    hstate_e       hs_q, hs_d;

    assign p = s2_q ^ INACT;

    // Two-flop synchroniser; resets to the idle pin level.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_q <= INACT;
        s2_q <= INACT;
      end else begin
        s1_q <= bus.i_btn[g];
        s2_q <= s1_q;
      end
    end

    // Debounce, pulse and hold-FSM state registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        hold_q  <= 1'b0;
        dc_q    <= '0;
        hc_q    <= '0;
        hs_q    <= HS_IDLE;
      end else begin
        state_q <= state_d;
        press_q <= press_d;
        rel_q   <= rel_d;
        hold_q  <= hold_d;
        dc_q    <= dc_d;
        hc_q    <= hc_d;
        hs_q    <= hs_d;
      end
    end

    // Next state: debounce first, then hold FSM; a level change overrides the FSM.
    always_comb begin
      state_d = state_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      hold_d  = 1'b0;
      dc_d    = '0;
      hc_d    = hc_q;
      hs_d    = hs_q;

      if (p != state_q) begin
        if (dc_q == DB_TC) begin
          state_d = p;
          press_d = p;
          rel_d   = ~p;
        end else begin
          dc_d = dc_q + 1'b1;
        end
      end

      case (hs_q)
        HS_IDLE: hc_d = '0;
        HS_PRESSED: begin
          if (hc_q == HOLD_TC) begin
            hold_d = 1'b1;
            hc_d   = '0;
            hs_d   = HS_REPEAT;
          end else begin
            hc_d = hc_q + 1'b1;
          end
        end
        HS_REPEAT: begin
          if (REPEAT_CYCLES == 0) begin
            hc_d = '0;
          end else if (hc_q == REP_TC) begin
            hold_d = 1'b1;
            hc_d   = '0;
          end else begin
            hc_d = hc_q + 1'b1;
          end
        end
        default: begin
          hs_d = HS_IDLE;
          hc_d = '0;
        end
      endcase

      // Press starts the hold timer; release kills any coincident hold pulse.
      if (press_d) begin
        hs_d   = HS_PRESSED;
        hc_d   = '0;
        hold_d = 1'b0;
      end
      if (rel_d) begin
        hs_d   = HS_IDLE;
        hc_d   = '0;
        hold_d = 1'b0;
      end
    end

    assign state_v[g] = state_q;
    assign press_v[g] = press_q;
    assign rel_v[g]   = rel_q;
    assign hold_v[g]  = hold_q;
  end

  assign bus.o_state   = state_v;
  assign bus.o_press   = press_v;
  assign bus.o_release = rel_v;
  assign bus.o_hold    = hold_v;

endmodule

// File: tb/tb_btn_reader.sv
// Directed bench for btn_reader: DB=4, HOLD=10, REPEAT=5, two channels.
// dut0: active-low, dut1: active-high, dut2: active-low with no repeats.
module tb_btn_reader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  btn_reader_if #(.NUM_BTN(2)) bus0 ();
  btn_reader_if #(.NUM_BTN(2)) bus1 ();
  btn_reader_if #(.NUM_BTN(2)) bus2 ();

  btn_reader #(.NUM_BTN(2), .ACTIVE_LOW(1), .DB_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(5))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  btn_reader #(.NUM_BTN(2), .ACTIVE_LOW(0), .DB_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(5))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  btn_reader #(.NUM_BTN(2), .ACTIVE_LOW(1), .DB_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(0))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // All driving and sampling happens on the falling edge.
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] all0(input logic [1:0] s, p, r, h);
    return {s, p, r, h};
  endfunction

  initial begin
    bus0.i_btn = 2'b11;
    bus1.i_btn = 2'b00;
    bus2.i_btn = 2'b11;
    rst_n = 1'b0;

    // Reset state
    #12;
    chk("rst_dut0", all0(bus0.o_state, bus0.o_press, bus0.o_release, bus0.o_hold), 8'h00);
    chk("rst_dut1", all0(bus1.o_state, bus1.o_press, bus1.o_release, bus1.o_hold), 8'h00);
    chk("rst_dut2", all0(bus2.o_state, bus2.o_press, bus2.o_release, bus2.o_hold), 8'h00);
    tick();
    rst_n = 1'b1;
    tick(3);
    chk("idle_dut0", all0(bus0.o_state, bus0.o_press, bus0.o_release, bus0.o_hold), 8'h00);

    // 1. Clean press: pulse 6 edges after the pin edge
    bus0.i_btn[0] = 1'b0;
    tick(5);
    chk("t1_press_early", bus0.o_press, 2'b00);
    tick();
    chk("t1_press", bus0.o_press, 2'b01);
    chk("t1_state", bus0.o_state, 2'b01);
    tick();
    chk("t1_press_one", bus0.o_press, 2'b00);
    chk("t1_state_hold", bus0.o_state, 2'b01);
    bus0.i_btn[0] = 1'b1;
    tick(5);
    chk("t1_rel_early", {bus0.o_state, bus0.o_release}, 4'b0100);
    tick();
    chk("t1_release", {bus0.o_state, bus0.o_release, bus0.o_press}, 6'b000100);
    tick();
    chk("t1_release_one", bus0.o_release, 2'b00);
    tick(4);

    // 2. Bounce in runs of 3: nothing accepted, then last run held
    for (int c = 0; c < 36; c++) begin
      bus0.i_btn[0] = (((c / 3) % 2) == 0) ? 1'b0 : 1'b1;
      tick();
      chk("t2_bounce", {bus0.o_state[0], bus0.o_press[0], bus0.o_release[0]}, 3'b000);
    end
    bus0.i_btn[0] = 1'b0;
    tick(5);
    chk("t2_press_early", bus0.o_press, 2'b00);
    tick();
    chk("t2_press", bus0.o_press, 2'b01);

    // 3. Hold/repeat at +10,+15,+20,+25 after o_press
    for (int k = 1; k < 30; k++) begin
      tick();
      chk("t3_hold", bus0.o_hold, (k == 10 || k == 15 || k == 20 || k == 25) ? 2'b01 : 2'b00);
    end
    // release at +29: repeat at +30 still fires, +35 coincides with the fall and is suppressed
    bus0.i_btn[0] = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      tick();
      chk("t3_rel_hold", bus0.o_hold, (j == 1) ? 2'b01 : 2'b00);
      chk("t3_rel_pulse", bus0.o_release, (j == 6) ? 2'b01 : 2'b00);
    end
    chk("t3_state_off", bus0.o_state, 2'b00);

    // 4. Release during hold at +12
    bus0.i_btn[0] = 1'b0;
    tick(6);
    chk("t4_press", bus0.o_press, 2'b01);
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("t4_hold", bus0.o_hold, (k == 10) ? 2'b01 : 2'b00);
    end
    bus0.i_btn[0] = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      tick();
      chk("t4_rel_hold", bus0.o_hold, (j == 3) ? 2'b01 : 2'b00);
      chk("t4_rel_pulse", bus0.o_release, (j == 6) ? 2'b01 : 2'b00);
    end
    bus0.i_btn[0] = 1'b0;
    tick(6);
    chk("t4_repress", bus0.o_press, 2'b01);
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("t4_rehold", bus0.o_hold, (k == 10) ? 2'b01 : 2'b00);
    end

    // 5. Async reset mid-hold (o_hold is high right now)
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_async", all0(bus0.o_state, bus0.o_press, bus0.o_release, bus0.o_hold), 8'h00);
    tick(2);
    rst_n = 1'b1;
    tick(5);
    chk("t5_press_early", {bus0.o_state, bus0.o_press}, 4'b0000);
    tick();
    chk("t5_press", {bus0.o_state, bus0.o_press}, 4'b0101);

    // 6. Simultaneous press, both polarities, and no-repeat variant
    bus0.i_btn = 2'b11;
    tick(12);
    chk("t6_idle", {bus0.o_state, bus1.o_state, bus2.o_state}, 6'b000000);
    bus0.i_btn = 2'b00;
    bus1.i_btn = 2'b11;
    bus2.i_btn = 2'b00;
    tick(5);
    chk("t6_press_early", {bus0.o_press, bus1.o_press, bus2.o_press}, 6'b000000);
    tick();
    chk("t6_press_dut0", bus0.o_press, 2'b11);
    chk("t6_press_dut1", bus1.o_press, 2'b11);
    chk("t6_press_dut2", bus2.o_press, 2'b11);
    chk("t6_state", {bus0.o_state, bus1.o_state, bus2.o_state}, 6'b111111);
    for (int k = 1; k <= 25; k++) begin
      tick();
      chk("t6_hold_dut0", bus0.o_hold, (k == 10 || k == 15 || k == 20 || k == 25) ? 2'b11 : 2'b00);
      chk("t6_hold_dut1", bus1.o_hold, (k == 10 || k == 15 || k == 20 || k == 25) ? 2'b11 : 2'b00);
      chk("t6_hold_dut2", bus2.o_hold, (k == 10) ? 2'b11 : 2'b00);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
